// File: rtl/ysyx_24070014_lsu.sv
// Load/store unit for the ysyx_24070014 core.
// Runs a single valid/ready transaction to a 32-bit word-addressed data memory.
// It formats store lanes and strobes, and returns aligned, extended load data.
// Illegal requests are answered directly from IDLE without touching memory.
module ysyx_24070014_lsu #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_LEN-1:0] req_addr,
    input  logic [DATA_LEN-1:0] req_wdata,
    output logic                resp_valid,
    output logic [DATA_LEN-1:0] resp_rdata,
    output logic                resp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_rdata,
    input  logic                mem_resp_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                state_q, state_d;
    logic                  write_q, write_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [ADDR_LEN-1:0]   addr_q, addr_d;
    logic [DATA_LEN-1:0]   wdata_q, wdata_d;
    logic [DATA_LEN-1:0]   rdata_q, rdata_d;
    logic                  err_q, err_d;

    // funct3[1:0] encodes size (00 byte, 01 half, 10 word); bit 2 marks unsigned loads.
    function automatic logic is_illegal(input logic wr, input logic [2:0] f3, input logic [1:0] off);
        logic bad_f3;
        logic misaligned;
        bad_f3     = (f3[1:0] == 2'b11) || (f3[2] && (wr || f3[1]));
        misaligned = ((f3[1:0] == 2'b01) && off[0]) ||
                     ((f3[1:0] == 2'b10) && (off != 2'b00));
        return bad_f3 || misaligned;
    endfunction

    // Bring the addressed lane down to bit 0, then sign- or zero-extend by size.
    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Memory-side outputs come straight from the latched request, so they stay stable until the handshake.
    always_comb begin
        mem_req_valid = (state_q == REQ);
        mem_we        = write_q;
        mem_addr      = {addr_q[ADDR_LEN-1:2], 2'b00};
        mem_wstrb     = 4'b0000;
        mem_wdata     = wdata_q;
        if (write_q) begin
            case (funct3_q[1:0])
                2'b00: begin
                    mem_wstrb = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: mem_wstrb = 4'b1111;
            endcase
        end
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        resp_rdata = rdata_q;
        resp_err   = err_q;
    end

    // Next-state and latch logic for the IDLE -> REQ -> WAIT -> RESP transaction.
    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    if (is_illegal(req_write, req_funct3, req_addr[1:0])) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = WAIT;
            end
            WAIT: begin
                if (mem_resp_valid) begin
                    err_d   = mem_resp_err;
                    rdata_d = (mem_resp_err || write_q) ? '0
                            : load_fmt(funct3_q, addr_q[1:0], mem_rdata);
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched request fields; reset abandons any outstanding access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_24070014_lsu.sv
// Directed testbench for ysyx_24070014_lsu with an expected-response queue.
module tb_ysyx_24070014_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_resp_valid, mem_resp_err;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ysyx_24070014_lsu #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One transaction: rdly cycles of mem_req_ready low, sdly cycles before the memory response.
    task automatic xact(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] mrdata, input logic merr,
                        input int rdly, input int sdly, input logic illegal,
                        input logic [3:0] xstrb, input logic [31:0] xwdata,
                        input logic [31:0] xrdata, input logic xerr);
        exp_t e;
        int   acc;
        int   guard;
        logic [31:0] xaddr;
        xaddr = {addr[31:2], 2'b00};
        chk1({tag, "_idle_ready"}, req_ready, 1'b1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        e.rdata = xrdata;
        e.err   = xerr;
        e.lat   = illegal ? 1 : 3 + rdly + sdly;
        sb.push_back(e);
        acc = cyc;
        step();
        req_valid  = 1'b0;
        req_write  = ~wr;
        req_funct3 = 3'b111;
        req_addr   = 32'h5A5A5A5B;
        req_wdata  = 32'hA5A5A5A5;
        if (!illegal) begin
            for (int i = 0; i <= rdly; i++) begin
                chk1({tag, "_mvalid"}, mem_req_valid, 1'b1);
                chk32({tag, "_maddr"}, mem_addr, xaddr);
                chk1({tag, "_mwe"}, mem_we, wr);
                chk32({tag, "_mstrb"}, {28'd0, mem_wstrb}, {28'd0, xstrb});
                chk32({tag, "_mwdata"}, mem_wdata, xwdata);
                chk1({tag, "_busy"}, req_ready, 1'b0);
                if (i < rdly) begin
                    mem_req_ready  = 1'b0;
                    mem_resp_valid = 1'b1;
                    mem_rdata      = 32'h0BADBAD0;
                    req_valid      = 1'b1;
                end else begin
                    mem_req_ready  = 1'b1;
                    mem_resp_valid = 1'b0;
                    req_valid      = 1'b0;
                end
                step();
            end
            mem_req_ready = 1'b0;
            req_valid     = 1'b0;
            for (int i = 0; i < sdly; i++) begin
                chk1({tag, "_wait_nomreq"}, mem_req_valid, 1'b0);
                chk1({tag, "_wait_noresp"}, resp_valid, 1'b0);
                step();
            end
            mem_resp_valid = 1'b1;
            mem_rdata      = mrdata;
            mem_resp_err   = merr;
            step();
            mem_resp_valid = 1'b0;
            mem_resp_err   = 1'b0;
            mem_rdata      = 32'h77777777;
        end else begin
            chk1({tag, "_no_mreq"}, mem_req_valid, 1'b0);
        end
        guard = 0;
        while (resp_valid !== 1'b1 && guard < 20) begin
            step();
            guard++;
        end
        chk1({tag, "_resp_seen"}, resp_valid, 1'b1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk32({tag, "_latency"}, 32'(cyc - acc), 32'(e.lat));
            chk32({tag, "_rdata"}, resp_rdata, e.rdata);
            chk1({tag, "_err"}, resp_err, e.err);
            step();
            chk1({tag, "_pulse_end"}, resp_valid, 1'b0);
            chk1({tag, "_ready_again"}, req_ready, 1'b1);
            chk32({tag, "_rdata_hold"}, resp_rdata, e.rdata);
            chk1({tag, "_err_hold"}, resp_err, e.err);
        end
    endtask

    // Start a lw, assert reset while in REQ or WAIT, then offer a stale memory response.
    task automatic abort_test(input string tag, input logic in_wait);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h80000040;
        step();
        req_valid = 1'b0;
        if (in_wait) begin
            mem_req_ready = 1'b1;
            step();
            mem_req_ready = 1'b0;
        end else begin
            chk1({tag, "_in_req"}, mem_req_valid, 1'b1);
        end
        #2 reset = 1'b0;
        #1;
        chk1({tag, "_mreq_drop"}, mem_req_valid, 1'b0);
        chk1({tag, "_ready_now"}, req_ready, 1'b1);
        chk1({tag, "_err_clr"}, resp_err, 1'b0);
        chk32({tag, "_rdata_clr"}, resp_rdata, 32'd0);
        step();
        reset = 1'b1;
        mem_resp_valid = 1'b1;
        mem_rdata      = 32'h13572468;
        step();
        mem_resp_valid = 1'b0;
        chk1({tag, "_late_ignored"}, resp_valid, 1'b0);
        chk1({tag, "_late_idle"}, req_ready, 1'b1);
        step();
        chk1({tag, "_late_ignored2"}, resp_valid, 1'b0);
        chk1({tag, "_no_mreq"}, mem_req_valid, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        mem_rdata = 32'd0; mem_resp_err = 1'b0;
        #3;
        chk1("rst_mreq", mem_req_valid, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk32("rst_strb", {28'd0, mem_wstrb}, 32'd0);
        chk32("rst_addr", mem_addr, 32'd0);
        chk32("rst_wdata", mem_wdata, 32'd0);
        chk1("rst_rvalid", resp_valid, 1'b0);
        chk32("rst_rdata", resp_rdata, 32'd0);
        chk1("rst_err", resp_err, 1'b0);
        chk1("rst_ready", req_ready, 1'b1);
        step();
        step();
        reset = 1'b1;
        step();

        // name, wr, f3, addr, wdata, mem_rdata, merr, rdly, sdly, illegal, strb, mwdata, rdata, err
        xact("lw",   1'b0, 3'b010, 32'h80000004, 32'h0, 32'hDEADBEEF, 1'b0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0);
        xact("lb3",  1'b0, 3'b000, 32'h80000013, 32'h0, 32'h8081F27F, 1'b0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFFFF80, 1'b0);
        xact("lbu3", 1'b0, 3'b100, 32'h80000013, 32'h0, 32'h8081F27F, 1'b0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h00000080, 1'b0);
        xact("lh2",  1'b0, 3'b001, 32'h80000012, 32'h0, 32'h8081F27F, 1'b0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFF8081, 1'b0);
        xact("lhu0", 1'b0, 3'b101, 32'h80000010, 32'h0, 32'h8081F27F, 1'b0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0000F27F, 1'b0);
        xact("lb1",  1'b0, 3'b000, 32'h80000011, 32'h0, 32'h8081F27F, 1'b0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'hFFFFFFF2, 1'b0);
        xact("sb",   1'b1, 3'b000, 32'h80000001, 32'h12345678, 32'hFFFFFFFF, 1'b0, 0, 0, 1'b0, 4'b0010, 32'h78787878, 32'h0, 1'b0);
        xact("sh",   1'b1, 3'b001, 32'h80000002, 32'h12345678, 32'hFFFFFFFF, 1'b0, 0, 0, 1'b0, 4'b1100, 32'h56785678, 32'h0, 1'b0);
        xact("sw",   1'b1, 3'b010, 32'h80000008, 32'h12345678, 32'hFFFFFFFF, 1'b0, 0, 0, 1'b0, 4'b1111, 32'h12345678, 32'h0, 1'b0);
        xact("mis",  1'b0, 3'b010, 32'h80000002, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b1);
        xact("f3",   1'b0, 3'b011, 32'h80000000, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b1);
        xact("sf3",  1'b1, 3'b100, 32'h80000000, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b1);
        xact("shmis",1'b1, 3'b001, 32'h80000003, 32'h0, 32'h0, 1'b0, 0, 0, 1'b1, 4'b0000, 32'h0, 32'h0, 1'b1);
        xact("stall",1'b0, 3'b010, 32'h80000020, 32'h0, 32'hCAFEF00D, 1'b0, 4, 2, 1'b0, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b0);
        xact("wrap", 1'b0, 3'b100, 32'hFFFFFFFF, 32'h0, 32'hA1B2C3D4, 1'b0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h000000A1, 1'b0);
        xact("buserr",1'b0,3'b010, 32'h80000010, 32'h0, 32'h11223344, 1'b1, 0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        abort_test("rst_wait", 1'b1);
        xact("buserr2",1'b0,3'b000,32'h80000010, 32'h0, 32'h11223344, 1'b1, 1, 0, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1);
        abort_test("rst_req", 1'b0);
        xact("post", 1'b0, 3'b010, 32'h80000044, 32'h0, 32'h0F0F0F0F, 1'b0, 0, 0, 1'b0, 4'b0000, 32'h0, 32'h0F0F0F0F, 1'b0);

        chk32("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ysyx_24070014_lsu.md
Name: ysyx_24070014_lsu

Overview:
- Load/store unit that sits directly downstream of the core's execute stage.
- Takes the ALU-computed address, store data and funct3, and runs a multi-cycle valid/ready transaction to a 32-bit word-addressed data memory.
- Returns aligned, sign/zero-extended load data to writeback.
- Replaces the current direct combinational memory access path; the core stalls while a request is outstanding.

Parameters:
- ADDR_LEN, 32, address width in bits
- DATA_LEN, 32, data width in bits (block supports 32 only)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- req_valid  in  1  core issues access
- req_ready  out  1  LSU can accept (IDLE)
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 of load/store
- req_addr  in  ADDR_LEN  byte address (ALU output)
- req_wdata  in  DATA_LEN  rs2 value for stores
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_LEN  extended load result
- resp_err  out  1  misaligned, illegal funct3, or bus error
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_LEN  word address, {req_addr[31:2],2'b00}
- mem_wdata  out  DATA_LEN  lane-replicated store data
- mem_wstrb  out  4  byte strobes
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_LEN  read word
- mem_resp_err  in  1  bus error

Behaviour:
- FSM states: IDLE, REQ, WAIT, RESP.
- Reset (reset=0, asynchronous):
  - state goes to IDLE; all latched fields clear to 0.
  - Outputs while in reset: mem_req_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1.
- IDLE:
  - req_ready=1.
  - On req_valid, latch write, funct3, addr and wdata.
  - If the request is illegal, go to RESP with err=1 and rdata=0, with no memory access. Illegal means either:
    - misaligned: h-type with addr[0]=1, or w-type with addr[1:0]!=0;
    - invalid funct3: loads allow only 000/001/010/100/101; stores allow only 000/001/010.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1; mem_addr, mem_we, mem_wdata and mem_wstrb are held stable from the latched request until the handshake.
  - When mem_req_ready=1, go to WAIT.
- WAIT:
  - mem_resp_valid is sampled only in this state.
  - On mem_resp_valid: capture the formatted rdata and err=mem_resp_err, then go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle (no response backpressure), then go to IDLE.
  - req_ready=0 in every state except IDLE.
- Store formatting (o = addr[1:0]):
  - sb: wstrb = 1<<o; wdata = byte replicated across 4 lanes.
  - sh: wstrb = 0011 (o=0) or 1100 (o=2); wdata = halfword replicated.
  - sw: wstrb = 1111; wdata as given.
  - Loads drive wstrb=0000 and we=0.
- Load formatting:
  - Shift mem_rdata right by 8*o.
  - lb/lh sign-extend from bit 7/15; lbu/lhu zero-extend; lw passes through.
- Response data rules:
  - Stores return resp_rdata=0.
  - Any error returns resp_rdata=0, resp_err=1.
  - resp_rdata and resp_err hold their value until the next RESP.
- Latency:
  - Accept in cycle 0; REQ in cycle 1 (ready=1); mem_resp_valid in cycle 2; resp_valid in cycle 3. Minimum is 3 cycles.
  - Each extra cycle of ready or response delay adds one cycle.
  - Errors detected in IDLE take 1 cycle.
- Boundary conditions:
  - req_valid outside IDLE is ignored and not queued.
  - mem_resp_valid in IDLE, REQ or RESP is ignored.
  - Reset asserted mid-transaction aborts it: mem_req_valid drops immediately and a late memory response is ignored.
  - Address wrap-around is not special: mem_addr is simply addr with bits [1:0] cleared.

Test Plan:
- Load word, zero-latency memory: lw at 0x80000004, mem_rdata=0xDEADBEEF -> mem_addr=0x80000004, wstrb=0000; resp_valid in cycle 3 with rdata 0xDEADBEEF, err=0.
- Byte/half loads of word 0x8081F27F:
  - lb at offset 3 -> 0xFFFFFF80; lbu at offset 3 -> 0x00000080.
  - lh at offset 2 -> 0xFFFF8081; lhu at offset 0 -> 0x0000F27F.
- Stores with req_wdata=0x12345678:
  - sb at 0x...01 -> wstrb=0010, wdata=0x78787878.
  - sh at 0x...02 -> wstrb=1100, wdata=0x56785678.
  - sw -> 1111, 0x12345678.
  - All stores respond with rdata=0.
- Errors:
  - lw at 0x...02 -> resp_valid the cycle after acceptance, err=1, mem_req_valid never asserts.
  - funct3=011 load -> same response.
  - mem_resp_err=1 on lw -> err=1, rdata=0.
- Stalls: mem_req_ready held low 4 cycles, then response delayed 2 cycles -> mem_addr, wstrb and wdata stable throughout; req_ready=0; resp_valid exactly one cycle at cycle 9.
- Reset in WAIT: reset=0 asynchronously -> mem_req_valid=0 and req_ready=1 immediately; a mem_resp_valid after release produces no resp_valid.
